csi_frame_writer: RTL and testbench
===================================

Name: csi_frame_writer

Overview:
- Sits between the CSI-2 packet decoder (camera) and the frame buffer.
- Takes decoded RAW8 long-packet words (4 pixels per 32-bit word) plus frame/line strobes.
- Crops each frame to WIDTH x HEIGHT and produces linear word addresses and write strobes for the buffer.
- Supports single-shot and continuous capture, a settle-frame skip after arming, and sticky error flags.

Parameters:
- WIDTH, 640, active pixels per line kept; must be a multiple of 4.
- HEIGHT, 480, active lines per frame kept.
- ADDR_W, 17, buffer word-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT/4.
- SKIP_FRAMES, 2, complete frames discarded after arming before capture (sensor settle).

Ports:
- clk  in  1  pixel/byte clock shared with the decoder and buffer.
- rst_n  in  1  asynchronous active-low reset.
- image_data  in  32  RAW8 word, pixel0 in [7:0].
- image_data_enable  in  1  one valid word per high cycle.
- frame_start  in  1  1-cycle pulse.
- frame_end  in  1  1-cycle pulse.
- line_start  in  1  1-cycle pulse.
- line_end  in  1  1-cycle pulse.
- capture_start  in  1  1-cycle arm request.
- continuous  in  1  1 = re-arm after every frame.
- clear_err  in  1  clears the sticky flags.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  word to the buffer.
- busy  out  1  state != IDLE.
- frame_done  out  1  1-cycle pulse at the end of a captured frame.
- frame_count  out  16  captured frames, wraps at 65535->0.
- short_line  out  1  sticky flag.
- short_frame  out  1  sticky flag.

Behaviour:
- Reset:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_count=0, short_line=0, short_frame=0.
  - State=IDLE; all counters 0.
- Constant: WPL = WIDTH/4 words per line.
- State machine IDLE / SKIP / ARMED / CAPTURE:
  - IDLE: on capture_start go to SKIP if SKIP_FRAMES>0, else ARMED; clear skip_cnt.
  - SKIP: each frame_end increments skip_cnt; when it reaches SKIP_FRAMES go to ARMED. All data is ignored.
  - ARMED: frame_start goes to CAPTURE and clears line_idx, word_idx, base, in_line. That same frame is captured.
  - CAPTURE, frame_end:
    - Raise short_frame if line_idx < HEIGHT.
    - Pulse frame_done and increment frame_count in the same cycle.
    - Next state is ARMED if continuous=1 (no re-skip), else IDLE.
  - CAPTURE, frame_start with no preceding frame_end: raise short_frame, clear the counters, stay in CAPTURE; frame_count is not incremented.
- Line tracking (CAPTURE only):
  - line_start sets in_line=1 and word_idx=0.
  - line_end:
    - Raise short_line if word_idx < WPL and line_idx < HEIGHT.
    - Clear in_line and word_idx.
    - If line_idx < HEIGHT, increment line_idx and add WPL to base. Once line_idx reaches HEIGHT it holds there.
  - Same-cycle line_end and line_start: the end is applied first, then the start, so in_line=1 afterwards.
- Word accept:
  - Condition: image_data_enable & in_line & line_idx < HEIGHT & word_idx < WPL, in CAPTURE.
  - On accept: wr_addr <= base + word_idx, wr_data <= image_data, wr_en <= 1, word_idx increments.
  - Latency is 1 cycle (outputs registered). wr_en is 0 on every other cycle.
  - Words beyond WPL, lines beyond HEIGHT, and words outside a line are dropped silently.
  - Enable in the same cycle as line_end: the word is accepted (if in range) before the line closes.
  - Enable in the same cycle as line_start (in_line still 0): the word is dropped.
- Address arithmetic:
  - base is an ADDR_W-bit running sum; no multiplier.
  - Maximum address is WIDTH*HEIGHT/4 - 1, so there is no wrap.
- Command rules:
  - capture_start while busy is ignored.
  - Deasserting continuous mid-frame finishes the current frame, then goes to IDLE.
  - clear_err has priority over a same-cycle set: flags read 0 the next cycle.
- Reset mid-frame: asynchronous return to reset values. A wr_en in flight is dropped; no partial write completes after reset.

Decomposition:
- Shared package csi_pkg:
  - State encoding enum (IDLE/SKIP/ARMED/CAPTURE).
  - CSI data-type constants (RAW8=6'h2A).
  - Function words_per_line(width).
- Sub-module: csi_line_tracker. It owns in_line, word_idx, line_idx and base, and emits accept and row-overflow signals. The top holds the FSM and flags.

Test Plan:
- Basic frame:
  - Stimulus: WIDTH=16, HEIGHT=4, SKIP_FRAMES=0. capture_start; frame of 4 lines x 4 words with data=line*16+word.
  - Required: 16 writes at addresses 0..15 with matching data; frame_done once; frame_count=1; state back to IDLE; no flags.
- Crop:
  - Stimulus: 6 lines x 6 words, same parameters.
  - Required: exactly 16 writes; max wr_addr=15; no short_line; no short_frame.
- Short line and short frame:
  - Stimulus: line 1 carries 2 words; frame_end after 3 lines.
  - Required: addresses 0-3, 4-5, 8-11 written; short_line=1; short_frame=1; clear_err clears both.
- Skip and continuous:
  - Stimulus: SKIP_FRAMES=2, continuous=1, 5 frames.
  - Required: frames 1-2 produce no writes; frames 3-5 captured; frame_count=3; busy stays 1.
- Restart and edge cases:
  - Stimulus A: frame_start mid-capture.
  - Required A: short_frame=1, addresses restart at 0, frame_count unchanged.
  - Stimulus B: enable coincident with line_end.
  - Required B: that word is written.
- Reset mid-frame:
  - Stimulus: drop rst_n during line 2.
  - Required: all outputs take reset values immediately; no wr_en until a new capture_start plus frame_start.

Source files
------------

// File: rtl/csi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csi_pkg
// Purpose  : Shared types, constants and helpers for the CSI frame writer.
// Revision : 1.0 - initial release
// ============================================================================
package csi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [5:0] C_DT_RAW8 = 6'h2A;

    // Four RAW8 pixels are packed into each 32-bit word.
    function automatic int words_per_line(input int width);
        return width / 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csi_line_tracker.sv
`default_nettype none
// ============================================================================
// Module   : csi_line_tracker
// Purpose  : Per-frame line/word position tracking, crop and address generation.
// Revision : 1.0 - initial release
// ============================================================================
module csi_line_tracker
    import csi_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic              clear,
    input  logic              line_start,
    input  logic              line_end,
    input  logic              data_enable,
    output logic              accept,
    output logic [ADDR_W-1:0] addr,
    output logic              line_short,
    output logic              rows_short
);

    localparam int LINE_W = $clog2(HEIGHT + 1);
    localparam logic [ADDR_W-1:0] c_wpl    = ADDR_W'(words_per_line(WIDTH));
    localparam logic [LINE_W-1:0] c_height = LINE_W'(HEIGHT);

    logic              r_in_line;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_base;
    logic [LINE_W-1:0] r_line_idx;

    logic              w_row_ok;
    logic              w_word_ok;
    logic [ADDR_W-1:0] w_word_cnt;

    assign w_row_ok   = (r_line_idx < c_height);
    assign w_word_ok  = (r_word_idx < c_wpl);
    assign accept     = active & data_enable & r_in_line & w_row_ok & w_word_ok;
    assign addr       = r_base + r_word_idx;
    // A word arriving with line_end still counts toward the line length.
    assign w_word_cnt = r_word_idx + ADDR_W'(accept);
    assign line_short = active & line_end & w_row_ok & (w_word_cnt < c_wpl);
    assign rows_short = w_row_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_line  <= 1'b0;
            r_word_idx <= '0;
            r_base     <= '0;
            r_line_idx <= '0;
        end else if (clear) begin
            r_in_line  <= 1'b0;
            r_word_idx <= '0;
            r_base     <= '0;
            r_line_idx <= '0;
        end else if (active) begin
            if (accept) begin
                r_word_idx <= r_word_idx + ADDR_W'(1);
            end
            if (line_end) begin
                r_in_line  <= 1'b0;
                r_word_idx <= '0;
                if (w_row_ok) begin
                    r_line_idx <= r_line_idx + LINE_W'(1);
                    r_base     <= r_base + c_wpl;
                end
            end
            // Start is applied after end so back-to-back lines reopen cleanly.
            if (line_start) begin
                r_in_line  <= 1'b1;
                r_word_idx <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/csi_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : csi_frame_writer
// Purpose  : Crops decoded RAW8 CSI frames and writes them to a linear buffer.
// Revision : 1.0 - initial release
// ============================================================================
module csi_frame_writer
    import csi_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int ADDR_W      = 17,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       image_data,
    input  logic              image_data_enable,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_start,
    input  logic              line_end,
    input  logic              capture_start,
    input  logic              continuous,
    input  logic              clear_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              short_line,
    output logic              short_frame
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_skip_cnt;

    logic              w_skip_clr;
    logic              w_skip_inc;
    logic              w_skip_last;
    logic              w_track_clr;
    logic              w_done;
    logic              w_restart;
    logic              w_active;
    logic              w_accept;
    logic              w_line_short;
    logic              w_rows_short;
    logic [ADDR_W-1:0] w_addr;

    assign w_active    = (r_state == ST_CAPTURE);
    assign w_skip_last = ((32'(r_skip_cnt) + 32'd1) >= 32'(SKIP_FRAMES));
    assign busy        = (r_state != ST_IDLE);

    csi_line_tracker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (w_active),
        .clear       (w_track_clr),
        .line_start  (line_start),
        .line_end    (line_end),
        .data_enable (image_data_enable),
        .accept      (w_accept),
        .addr        (w_addr),
        .line_short  (w_line_short),
        .rows_short  (w_rows_short)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_skip_clr  = 1'b0;
        w_skip_inc  = 1'b0;
        w_track_clr = 1'b0;
        w_done      = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (capture_start) begin
                    w_skip_clr  = 1'b1;
                    w_state_nxt = (SKIP_FRAMES > 0) ? ST_SKIP : ST_ARMED;
                end
            end
            ST_SKIP: begin
                if (frame_end) begin
                    w_skip_inc = 1'b1;
                    if (w_skip_last) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    w_track_clr = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (frame_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = continuous ? ST_ARMED : ST_IDLE;
                end else if (frame_start) begin
                    // Missing frame_end: restart the capture on this new frame.
                    w_restart   = 1'b1;
                    w_track_clr = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_skip_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_skip_clr) begin
                r_skip_cnt <= '0;
            end else if (w_skip_inc) begin
                r_skip_cnt <= r_skip_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            short_line  <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            wr_en      <= w_accept;
            frame_done <= w_done;
            if (w_accept) begin
                wr_addr <= w_addr;
                wr_data <= image_data;
            end
            if (w_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (clear_err) begin
                short_line  <= 1'b0;
                short_frame <= 1'b0;
            end else begin
                if (w_line_short) begin
                    short_line <= 1'b1;
                end
                if ((w_done & w_rows_short) | w_restart) begin
                    short_frame <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csi_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi_frame_writer
// Purpose  : Directed scoreboard bench for csi_frame_writer (16x4 crop, 2 skip).
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi_frame_writer;

    localparam int WIDTH       = 16;
    localparam int HEIGHT      = 4;
    localparam int ADDR_W      = 6;
    localparam int SKIP_FRAMES = 2;
    localparam int WPL         = WIDTH / 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       image_data;
    logic              image_data_enable;
    logic              frame_start;
    logic              frame_end;
    logic              line_start;
    logic              line_end;
    logic              capture_start;
    logic              continuous;
    logic              clear_err;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_count;
    logic              short_line;
    logic              short_frame;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } sb_t;

    sb_t sb[$];
    int  n_asserts = 0;
    int  n_fail    = 0;
    int  n_wr      = 0;
    int  n_push    = 0;

    always #5 clk = ~clk;

    csi_frame_writer #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .ADDR_W      (ADDR_W),
        .SKIP_FRAMES (SKIP_FRAMES)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .image_data        (image_data),
        .image_data_enable (image_data_enable),
        .frame_start       (frame_start),
        .frame_end         (frame_end),
        .line_start        (line_start),
        .line_end          (line_end),
        .capture_start     (capture_start),
        .continuous        (continuous),
        .clear_err         (clear_err),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_count       (frame_count),
        .short_line        (short_line),
        .short_frame       (short_frame)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int addr, input logic [31:0] data);
        sb_t e;
        e.a = ADDR_W'(addr);
        e.d = data;
        sb.push_back(e);
        n_push++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        frame_start       = 1'b0;
        frame_end         = 1'b0;
        line_start        = 1'b0;
        line_end          = 1'b0;
        image_data_enable = 1'b0;
        capture_start     = 1'b0;
        clear_err         = 1'b0;
    endtask

    task automatic send_frame(input int lines, input int words, input int short_ln,
                              input int short_w, input bit capt, input bit coincide,
                              input bit do_end, input int tag);
        frame_start = 1'b1;
        tick();
        for (int l = 0; l < lines; l++) begin
            int nw;
            nw = (l == short_ln) ? short_w : words;
            line_start = 1'b1;
            tick();
            for (int w = 0; w < nw; w++) begin
                image_data        = {8'(tag), 8'(l), 8'(w), 8'hA5};
                image_data_enable = 1'b1;
                if (capt && l < HEIGHT && w < WPL) push(l * WPL + w, image_data);
                if (coincide && w == nw - 1) line_end = 1'b1;
                tick();
            end
            if (!coincide || nw == 0) begin
                line_end = 1'b1;
                tick();
            end
        end
        if (do_end) begin
            frame_end = 1'b1;
            tick();
        end
    endtask

    task automatic arm_and_skip(input int tag);
        capture_start = 1'b1;
        tick();
        check("busy_after_arm", 64'(busy), 64'(1));
        for (int f = 0; f < SKIP_FRAMES; f++) begin
            send_frame(HEIGHT, WPL, -1, 0, 1'b0, 1'b0, 1'b1, tag + f);
        end
    endtask

    // Write monitor: every buffer write must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            n_wr++;
            n_asserts++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_write observed addr=%0h data=%0h expected=no write",
                       wr_addr, wr_data);
            end
            if (sb.size() > 0) begin
                sb_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.a));
                check("wr_data", 64'(wr_data), 64'(e.d));
            end
        end
    end

    initial begin
        int w0;
        rst_n             = 1'b0;
        image_data        = '0;
        image_data_enable = 1'b0;
        frame_start       = 1'b0;
        frame_end         = 1'b0;
        line_start        = 1'b0;
        line_end          = 1'b0;
        capture_start     = 1'b0;
        continuous        = 1'b0;
        clear_err         = 1'b0;
        tick();
        tick();
        check("rst_wr_en",       64'(wr_en),       64'(0));
        check("rst_wr_addr",     64'(wr_addr),     64'(0));
        check("rst_wr_data",     64'(wr_data),     64'(0));
        check("rst_busy",        64'(busy),        64'(0));
        check("rst_frame_done",  64'(frame_done),  64'(0));
        check("rst_frame_count", 64'(frame_count), 64'(0));
        check("rst_short_line",  64'(short_line),  64'(0));
        check("rst_short_frame", 64'(short_frame), 64'(0));
        rst_n = 1'b1;
        tick();

        // Basic frame: 4 lines x 4 words, captured after two settle frames
        arm_and_skip(8'h10);
        w0 = n_wr;
        send_frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b1, 8'h01);
        check("basic_frame_done",  64'(frame_done),  64'(1));
        check("basic_frame_count", 64'(frame_count), 64'(1));
        check("basic_busy",        64'(busy),        64'(0));
        check("basic_writes",      64'(n_wr - w0),   64'(16));
        tick();
        check("basic_done_pulse",  64'(frame_done),  64'(0));
        check("basic_short_line",  64'(short_line),  64'(0));
        check("basic_short_frame", 64'(short_frame), 64'(0));

        // Crop: 6 lines x 6 words keeps only 4 x 4
        arm_and_skip(8'h20);
        w0 = n_wr;
        send_frame(6, 6, -1, 0, 1'b1, 1'b0, 1'b1, 8'h02);
        check("crop_frame_count", 64'(frame_count), 64'(2));
        tick();
        check("crop_writes",      64'(n_wr - w0),   64'(16));
        check("crop_short_line",  64'(short_line),  64'(0));
        check("crop_short_frame", 64'(short_frame), 64'(0));

        // Short line (line 1 has 2 words) and short frame (3 lines)
        arm_and_skip(8'h30);
        w0 = n_wr;
        send_frame(3, 4, 1, 2, 1'b1, 1'b0, 1'b1, 8'h03);
        tick();
        check("short_writes",      64'(n_wr - w0),   64'(10));
        check("short_line_set",    64'(short_line),  64'(1));
        check("short_frame_set",   64'(short_frame), 64'(1));
        check("short_frame_count", 64'(frame_count), 64'(3));
        clear_err = 1'b1;
        tick();
        check("clear_short_line",  64'(short_line),  64'(0));
        check("clear_short_frame", 64'(short_frame), 64'(0));

        // Continuous: 5 frames, first two skipped, busy held throughout
        continuous = 1'b1;
        arm_and_skip(8'h40);
        for (int f = 0; f < 3; f++) begin
            send_frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b1, 8'h50 + f);
            check("cont_busy", 64'(busy), 64'(1));
        end
        tick();
        check("cont_frame_count", 64'(frame_count), 64'(6));
        check("cont_no_flags",    64'({short_line, short_frame}), 64'(0));

        // Restart: frame_start mid-capture with no frame_end
        send_frame(2, 4, 1, 2, 1'b1, 1'b0, 1'b0, 8'h60);
        check("restart_count_before", 64'(frame_count), 64'(6));
        send_frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b1, 8'h61);
        check("restart_short_frame", 64'(short_frame), 64'(1));
        check("restart_frame_count", 64'(frame_count), 64'(7));
        clear_err = 1'b1;
        tick();

        // Enable coincident with line_end; continuous dropped before the frame
        continuous = 1'b0;
        w0 = n_wr;
        send_frame(4, 4, -1, 0, 1'b1, 1'b1, 1'b1, 8'h70);
        check("coinc_frame_count", 64'(frame_count), 64'(8));
        check("coinc_busy",        64'(busy),        64'(0));
        tick();
        check("coinc_writes",      64'(n_wr - w0),   64'(16));
        check("coinc_short_line",  64'(short_line),  64'(0));

        // Reset during line 2 with a write in flight
        arm_and_skip(8'h80);
        send_frame(2, 4, -1, 0, 1'b1, 1'b0, 1'b0, 8'h90);
        line_start = 1'b1;
        tick();
        image_data        = 32'hDEAD_BEEF;
        image_data_enable = 1'b1;
        tick();
        check("inflight_wr_en", 64'(wr_en), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en",       64'(wr_en),       64'(0));
        check("mid_rst_wr_addr",     64'(wr_addr),     64'(0));
        check("mid_rst_wr_data",     64'(wr_data),     64'(0));
        check("mid_rst_busy",        64'(busy),        64'(0));
        check("mid_rst_frame_count", 64'(frame_count), 64'(0));
        check("mid_rst_flags",       64'({frame_done, short_line, short_frame}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        w0 = n_wr;
        send_frame(4, 4, -1, 0, 1'b0, 1'b0, 1'b1, 8'hA0);
        check("no_write_unarmed", 64'(n_wr - w0), 64'(0));
        arm_and_skip(8'hB0);
        send_frame(4, 4, -1, 0, 1'b1, 1'b0, 1'b1, 8'hC0);
        check("post_rst_frame_count", 64'(frame_count), 64'(1));
        tick();
        tick();

        check("sb_empty",     64'(sb.size()), 64'(0));
        check("total_writes", 64'(n_wr),      64'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
